// File: rtl/mem_bus_pkg.sv
// Shared access codes, FSM states and lane helpers for the memory bus controller.
// Pure declarations and combinational functions; no latency.
// No flow control of its own.
package mem_bus_pkg;

    localparam logic [2:0] FUNC_BS = 3'b000;
    localparam logic [2:0] FUNC_HS = 3'b001;
    localparam logic [2:0] FUNC_WD = 3'b010;
    localparam logic [2:0] FUNC_BU = 3'b100;
    localparam logic [2:0] FUNC_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} accSize_t;

    // Attributes of the accepted access needed after the request phase.
    typedef struct packed {
        logic       isRead;
        logic [2:0] func;
        logic [1:0] lane;
    } reqInfo_t;

    // Unlisted codes fall back to a word access.
    function automatic accSize_t accessSize(input logic [2:0] func);
        case (func)
            FUNC_BS, FUNC_BU: return SZ_BYTE;
            FUNC_HS, FUNC_HU: return SZ_HALF;
            default:          return SZ_WORD;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] func, input logic [1:0] addr);
        case (accessSize(func))
            SZ_BYTE: return 4'b0001 << addr;
            SZ_HALF: return 4'b0011 << {addr[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] func, input logic [1:0] addr);
        case (accessSize(func))
            SZ_HALF: return addr[0];
            SZ_WORD: return addr != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of bus read data and sign/zero extends it.
// Purely combinational, zero latency.
// No flow control; result follows inputs.
module mem_load_align
    import mem_bus_pkg::*;
(
    input  logic [31:0] BusRData,
    input  logic [2:0]  func,
    input  logic [1:0]  addr,
    output logic [31:0] result
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic        signExt;

    always_comb begin
        byteLane = 8'h00;
        case (addr)
            2'd0: byteLane = BusRData[7:0];
            2'd1: byteLane = BusRData[15:8];
            2'd2: byteLane = BusRData[23:16];
            2'd3: byteLane = BusRData[31:24];
            default: byteLane = BusRData[7:0];
        endcase
        halfLane = addr[1] ? BusRData[31:16] : BusRData[15:0];
        // Bit 2 of the code distinguishes unsigned byte/half from the signed forms.
        signExt  = ~func[2];

        result = BusRData;
        case (accessSize(func))
            SZ_BYTE: result = {{24{signExt & byteLane[7]}}, byteLane};
            SZ_HALF: result = {{16{signExt & halfLane[15]}}, halfLane};
            default: result = BusRData;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Turns MEM-stage loads/stores into single off-chip bus transactions with BE and replicated data.
// Accept cycle + one or more REQ cycles + DONE; zero-wait access stalls 2 cycles, load result in the 3rd.
// Stalls the pipeline until BusAck or timeout; misaligned accesses are rejected without stalling.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int AW      = 16
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [2:0]    Memfunc,
    input  logic [AW-1:0] MemAddr,
    input  logic [31:0]   MemWriteData,
    output logic          Stall,
    output logic [31:0]   LoadData,
    output logic          LoadValid,
    output logic          AlignErr,
    output logic          BusErr,
    output logic          BusReq,
    output logic          BusWe,
    output logic [AW-3:0] BusAddr,
    output logic [3:0]    BusBE,
    output logic [31:0]   BusWData,
    input  logic [31:0]   BusRData,
    input  logic          BusAck
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     nextState;
    logic [7:0] reqCnt;
    reqInfo_t   info;
    logic       acc;
    logic       aligned;
    logic       accept;
    logic       reject;
    logic       ackHit;
    logic       timedOut;
    logic [31:0] alignedData;

    function automatic logic [31:0] replicate(input logic [2:0] func, input logic [31:0] d);
        case (accessSize(func))
            SZ_BYTE: return {4{d[7:0]}};
            SZ_HALF: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        acc       = MemRead | MemWrite;
        aligned   = ~misaligned(Memfunc, MemAddr[1:0]);
        nextState = state;
        accept    = 1'b0;
        reject    = 1'b0;
        ackHit    = 1'b0;
        timedOut  = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (aligned) begin
                        accept    = 1'b1;
                        nextState = REQ;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            REQ: begin
                // An ack arriving on the final counted cycle still completes normally.
                if (BusAck) begin
                    ackHit    = 1'b1;
                    nextState = DONE;
                end else if (reqCnt == CNT_LAST) begin
                    timedOut  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
        BusReq = (state == REQ);
        Stall  = accept | (state == REQ);
    end

    // Bus-side registers stay frozen from accept until the next accept.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            BusWe    <= 1'b0;
            BusAddr  <= '0;
            BusBE    <= 4'b0000;
            BusWData <= 32'h0;
            info     <= '0;
        end else if (accept) begin
            BusWe       <= MemWrite;
            BusAddr     <= MemAddr[AW-1:2];
            BusBE       <= byte_en(Memfunc, MemAddr[1:0]);
            BusWData    <= replicate(Memfunc, MemWriteData);
            info.isRead <= ~MemWrite;
            info.func   <= Memfunc;
            info.lane   <= MemAddr[1:0];
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            reqCnt <= 8'h00;
        end else if (state == REQ && nextState == REQ) begin
            reqCnt <= reqCnt + 8'h01;
        end else begin
            reqCnt <= 8'h00;
        end
    end

    mem_load_align u_align (
        .BusRData (BusRData),
        .func     (info.func),
        .addr     (info.lane),
        .result   (alignedData)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            LoadData  <= 32'h0;
            LoadValid <= 1'b0;
            AlignErr  <= 1'b0;
            BusErr    <= 1'b0;
        end else begin
            LoadValid <= ackHit & info.isRead;
            AlignErr  <= reject;
            BusErr    <= timedOut;
            if (ackHit && info.isRead) begin
                LoadData <= alignedData;
            end else if ((timedOut && info.isRead) || (reject && MemRead && !MemWrite)) begin
                LoadData <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed vector table, randomized accesses against a behavioural model,
// and an asynchronous reset during a wait state.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    localparam int TIMEOUT = 16;
    localparam int AW      = 16;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic          MemRead = 1'b0;
    logic          MemWrite = 1'b0;
    logic [2:0]    Memfunc = 3'b000;
    logic [AW-1:0] MemAddr = '0;
    logic [31:0]   MemWriteData = 32'h0;
    logic          Stall;
    logic [31:0]   LoadData;
    logic          LoadValid;
    logic          AlignErr;
    logic          BusErr;
    logic          BusReq;
    logic          BusWe;
    logic [AW-3:0] BusAddr;
    logic [3:0]    BusBE;
    logic [31:0]   BusWData;
    logic [31:0]   BusRData = 32'h0;
    logic          BusAck = 1'b0;

    always #5 Clock = ~Clock;

    mem_bus_ctrl #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
        .Clock(Clock), .nReset(nReset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Memfunc(Memfunc), .MemAddr(MemAddr), .MemWriteData(MemWriteData),
        .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid), .AlignErr(AlignErr),
        .BusErr(BusErr), .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusBE(BusBE),
        .BusWData(BusWData), .BusRData(BusRData), .BusAck(BusAck)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  func;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          ackDelay;   // REQ cycle index of the ack; -1 = never
        logic [31:0] rdata;
        logic [3:0]  expBE;
        logic [31:0] expWData;
        logic [31:0] expLoad;    // LoadData expected after the access completes
    } vec_t;

    int          nChecks = 0;
    int          nPass = 0;
    logic [31:0] modelLoad = 32'h0;
    vec_t        tbl[12];

    task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", tag, what, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int sizeOf(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic modelMis(input logic [2:0] f, input logic [1:0] a);
        return (int'(a) % sizeOf(f)) != 0;
    endfunction

    function automatic logic [3:0] modelBE(input logic [2:0] f, input logic [1:0] a);
        int sz = sizeOf(f);
        return 4'(((1 << sz) - 1) << a);
    endfunction

    function automatic logic [31:0] modelWData(input logic [2:0] f, input logic [31:0] d);
        int sz = sizeOf(f);
        if (sz == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] modelExtract(input logic [2:0] f, input logic [1:0] a, input logic [31:0] r);
        int sz = sizeOf(f);
        logic [31:0] mask;
        logic [31:0] v;
        if (sz == 4) return r;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = (r >> (8 * a)) & mask;
        if (f[2] == 1'b0 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f, input logic [15:0] a,
                                input logic [31:0] wd, input int dly, input logic [31:0] rdat,
                                input logic [3:0] be, input logic [31:0] ewd, input logic [31:0] eld);
        vec_t v;
        v.rd = rd; v.wr = wr; v.func = f; v.addr = a; v.wdata = wd; v.ackDelay = dly;
        v.rdata = rdat; v.expBE = be; v.expWData = ewd; v.expLoad = eld;
        return v;
    endfunction

    task automatic dropAccess();
        MemRead = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check(tag, "BusReq", BusReq, 0);
        check(tag, "Stall", Stall, 0);
        check(tag, "LoadData", LoadData, 0);
        check(tag, "LoadValid", LoadValid, 0);
        check(tag, "AlignErr", AlignErr, 0);
        check(tag, "BusErr", BusErr, 0);
        check(tag, "BusWe", BusWe, 0);
        check(tag, "BusAddr", 32'(BusAddr), 0);
        check(tag, "BusBE", 32'(BusBE), 0);
        check(tag, "BusWData", BusWData, 0);
    endtask

    // One MEM-stage access, held until the pipeline is released, checked cycle by cycle.
    task automatic doTxn(input vec_t v, input string tag);
        logic isRd;
        logic mis;
        int   reqCycles;
        isRd = v.rd && !v.wr;
        mis  = modelMis(v.func, v.addr[1:0]);
        @(posedge Clock); #1;
        MemRead = v.rd; MemWrite = v.wr; Memfunc = v.func; MemAddr = v.addr; MemWriteData = v.wdata;
        @(negedge Clock);
        check(tag, "BusReq0", BusReq, 0);
        if (!(v.rd || v.wr)) begin
            check(tag, "idleStall", Stall, 0);
            return;
        end
        check(tag, "Stall0", Stall, 32'(!mis));
        if (mis) begin
            @(posedge Clock); #1; dropAccess();
            @(negedge Clock);
            check(tag, "AlignErr", AlignErr, 1);
            check(tag, "LoadData", LoadData, v.expLoad);
            check(tag, "LoadValid", LoadValid, 0);
            check(tag, "BusReqMis", BusReq, 0);
            @(negedge Clock);
            check(tag, "AlignErrPulse", AlignErr, 0);
            modelLoad = v.expLoad;
            return;
        end
        reqCycles = (v.ackDelay < 0) ? TIMEOUT : v.ackDelay + 1;
        for (int k = 0; k < reqCycles; k++) begin
            @(posedge Clock); #1;
            BusAck   = (k == v.ackDelay);
            BusRData = BusAck ? v.rdata : $urandom;
            @(negedge Clock);
            check(tag, "BusReq", BusReq, 1);
            check(tag, "Stall", Stall, 1);
            if (k == 0 || k == reqCycles - 1) begin
                check(tag, "BusWe", BusWe, 32'(v.wr));
                check(tag, "BusAddr", 32'(BusAddr), 32'(v.addr >> 2));
                check(tag, "BusBE", 32'(BusBE), 32'(v.expBE));
                check(tag, "BusWData", BusWData, v.expWData);
            end
        end
        @(posedge Clock); #1;
        BusAck = 1'b0;
        @(negedge Clock);
        check(tag, "DoneBusReq", BusReq, 0);
        check(tag, "DoneStall", Stall, 0);
        check(tag, "LoadValid", LoadValid, 32'(isRd && v.ackDelay >= 0));
        check(tag, "BusErr", BusErr, 32'(v.ackDelay < 0));
        check(tag, "LoadData", LoadData, v.expLoad);
        @(posedge Clock); #1; dropAccess();
        @(negedge Clock);
        check(tag, "LoadValidPulse", LoadValid, 0);
        check(tag, "BusErrPulse", BusErr, 0);
        check(tag, "IdleStall", Stall, 0);
        modelLoad = v.expLoad;
    endtask

    initial begin
        vec_t v;
        int   r;
        logic isRd;

        tbl[0]  = mk(1, 0, 3'b000, 16'h0013, 32'h0, 0, 32'h80FF_7F00, 4'b1000, 32'h0, 32'hFFFF_FF80);
        tbl[1]  = mk(0, 1, 3'b001, 16'h0022, 32'h1234_ABCD, 3, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80);
        tbl[2]  = mk(1, 0, 3'b010, 16'h0006, 32'h0, 0, 32'h0, 4'b1111, 32'h0, 32'h0);
        tbl[3]  = mk(1, 0, 3'b100, 16'h0001, 32'h0, -1, 32'h0, 4'b0010, 32'h0, 32'h0);
        tbl[4]  = mk(1, 0, 3'b100, 16'h0001, 32'h0, TIMEOUT - 1, 32'h0000_5A00, 4'b0010, 32'h0, 32'h0000_005A);
        tbl[5]  = mk(1, 1, 3'b010, 16'h0100, 32'hCAFE_F00D, 1, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0000_005A);
        tbl[6]  = mk(1, 0, 3'b100, 16'h0102, 32'h0, 0, 32'h00AB_0000, 4'b0100, 32'h0, 32'h0000_00AB);
        tbl[7]  = mk(1, 0, 3'b001, 16'h0002, 32'h0, 2, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001);
        tbl[8]  = mk(0, 1, 3'b000, 16'h0011, 32'h0000_00A5, 0, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_8001);
        tbl[9]  = mk(1, 0, 3'b101, 16'h0003, 32'h0, 0, 32'h0, 4'b0000, 32'h0, 32'h0);
        tbl[10] = mk(1, 0, 3'b101, 16'h0042, 32'h0, 1, 32'h8001_FFFF, 4'b1100, 32'h0, 32'h0000_8001);
        tbl[11] = mk(1, 0, 3'b011, 16'h0008, 32'h0, 0, 32'h89AB_CDEF, 4'b1111, 32'h0, 32'h89AB_CDEF);

        #2;
        checkAllZero("reset");
        repeat (2) @(negedge Clock);
        nReset = 1'b1;

        for (int i = 0; i < 12; i++) doTxn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            v.rd = (r >= 1 && r <= 4) || r == 9;
            v.wr = (r >= 5);
            v.func = 3'($urandom_range(0, 7));
            v.addr = 16'($urandom);
            v.wdata = $urandom;
            v.rdata = $urandom;
            r = $urandom_range(0, 9);
            v.ackDelay = (r == 0) ? -1 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
            v.expBE = modelBE(v.func, v.addr[1:0]);
            v.expWData = modelWData(v.func, v.wdata);
            isRd = v.rd && !v.wr;
            if (!isRd) v.expLoad = modelLoad;
            else if (modelMis(v.func, v.addr[1:0]) || v.ackDelay < 0) v.expLoad = 32'h0;
            else v.expLoad = modelExtract(v.func, v.addr[1:0], v.rdata);
            doTxn(v, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset while a store sits in a wait state.
        doTxn(tbl[0], "preRst");
        @(posedge Clock); #1;
        MemWrite = 1'b1; Memfunc = 3'b000; MemAddr = 16'h0013; MemWriteData = 32'h0000_00FF;
        repeat (4) @(negedge Clock);
        check("midRst", "BusReqBefore", BusReq, 1);
        check("midRst", "BusWeBefore", BusWe, 1);
        check("midRst", "LoadDataBefore", LoadData, 32'hFFFF_FF80);
        #1;
        nReset = 1'b0;
        dropAccess();
        #1;
        checkAllZero("midRst");
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        modelLoad = 32'h0;
        @(negedge Clock);
        check("postRst", "Stall", Stall, 0);
        check("postRst", "BusReq", BusReq, 0);
        doTxn(tbl[0], "postRst");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sits directly downstream of the MEM stage and owns the off-chip memory bus.
- Converts each MEM-stage load/store into a bus transaction with byte enables and lane-replicated write data.
- Stalls the pipeline while the transaction is outstanding.
- Returns aligned, sign- or zero-extended load data to the WB stage.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: REQ cycles without BusAck before abort; legal range 2..255.
- AW, 16: byte address width; matches MemAddr.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- MemRead  in  1  load request from MEM stage.
- MemWrite  in  1  store request from MEM stage.
- Memfunc  in  3  access size/sign code.
- MemAddr  in  AW  byte address.
- MemWriteData  in  32  store data, right-justified.
- Stall  out  1  hold the pipeline; combinational.
- LoadData  out  32  extended load result; registered.
- LoadValid  out  1  one-cycle pulse when LoadData is updated by a load.
- AlignErr  out  1  one-cycle pulse, misaligned access.
- BusErr  out  1  one-cycle pulse, timeout.
- BusReq  out  1  bus request.
- BusWe  out  1  1 = write.
- BusAddr  out  AW-2  word address.
- BusBE  out  4  byte enables, bit i = byte lane i (little-endian).
- BusWData  out  32  lane-replicated write data.
- BusRData  in  32  read data, valid when BusAck = 1.
- BusAck  in  1  transaction complete.

Behaviour:
- Clock and reset: single clock (Clock), asynchronous active-low reset (nReset).
- Reset values: state IDLE; BusReq, BusWe, BusAddr, BusBE, BusWData, LoadData, LoadValid, AlignErr, BusErr all 0; timeout counter 0. Reset mid-transaction drops BusReq immediately; no completion is reported.
- Memfunc codes: BS=000 (signed byte), HS=001 (signed half), WD=010 (word), BU=100 (unsigned byte), HU=101 (unsigned half). Any other code is treated as WD.
- Access request: acc = MemRead | MemWrite. If both are high, the write wins and the read is ignored.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠00.
- State IDLE:
  - acc & aligned: latch address, func, write flag, BE and WData into the bus registers; go to REQ.
  - acc & misaligned: no bus cycle; AlignErr=1 next cycle; LoadData=0 next cycle if the access was a read; stay IDLE.
- State REQ:
  - BusReq=1, with BusWe/BusAddr/BusBE/BusWData held stable.
  - Counter increments each REQ cycle.
  - BusAck: go to DONE. On a read, LoadData ← extend(BusRData) and LoadValid=1, both in the DONE cycle.
  - Counter reaches TIMEOUT-1 without ack: go to DONE with BusErr=1; LoadData=0 on a read.
  - BusAck on the same cycle as the timeout: the ack wins.
- State DONE: BusReq=0, Stall=0; the pipeline advances. Next state is IDLE unconditionally; a new access is accepted only from IDLE.
- Stall = (IDLE & acc & aligned) | REQ.
- Latency with zero-wait memory (ack in the first REQ cycle): Stall high for 2 cycles; LoadValid in the 3rd cycle.
- Byte enables:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << {addr[1],1'b0}.
  - Word: 1111.
- Write data replication:
  - Byte: {4{d[7:0]}}.
  - Half: {2{d[15:0]}}.
  - Word: d.
- Read extraction: select lane(s) by the latched addr[1:0]. Sign-extend for BS/HS, zero-extend for BU/HU.
- LoadData holds its value until the next read completion, misaligned read, timed-out read, or reset.

Decomposition:
- Package mem_bus_pkg holds:
  - Memfunc code constants.
  - state_t enum {IDLE, REQ, DONE}.
  - Function byte_en(func, addr[1:0]).
  - Function misaligned(func, addr[1:0]).
- Sub-module mem_load_align: combinational lane select and extension; inputs BusRData, func, addr[1:0]; output 32-bit result.

Test Plan:
- Load zero-wait: MemRead, BS, addr 0x0013, BusRData 0x80FF_7F00, ack in first REQ cycle → BusReq 1 cycle, BusAddr 0x0004, BusBE 1000, Stall 2 cycles, LoadData 0xFFFF_FF80, LoadValid 1 cycle.
- Store half, 3 wait states: MemWrite, HS, addr 0x0022, data 0x1234_ABCD → BusWe=1, BusBE 1100, BusWData 0xABCD_ABCD held 4 cycles; Stall 5 cycles; no LoadValid.
- Misaligned: MemRead, WD, addr 0x0006 → no BusReq, Stall 0, AlignErr pulse, LoadData 0.
- Timeout: TIMEOUT=16, MemRead, BU, addr 0x0001, BusAck never asserted → BusReq 16 cycles, then BusErr pulse, LoadData 0; ack together with the last count → normal completion, BusErr 0.
- Read/write priority and zero-extension: MemRead=MemWrite=1, WD, addr 0x0100 → write issued, BusBE 1111, no LoadValid; then BU read addr 0x0102, BusRData 0x00AB_0000 → LoadData 0x0000_00AB.
- Reset mid-REQ: nReset low during a wait state → BusReq and Stall drop asynchronously; all outputs 0; IDLE after release.
